// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle multiply/divide unit beside the EX-stage ALU.
// Sequences MULT/MULTU/DIV/DIVU, one iteration per clock for DATA_WIDTH iterations.
// It owns the architectural HI/LO registers and stalls IF/ID/EX while an operation
// is in flight.
//
// Ports:
//   Clk          rising-edge clock
//   Reset        asynchronous active-high reset; aborts any operation
//   start        EX holds a mul/div instruction; held high while stalled
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_val       multiplicand / dividend
//   rt_val       multiplier / divisor
//   flush        squashes the start in IDLE or the operation in BUSY
//   hi_we/lo_we  MTHI/MTLO write enables, with data on wdata
//   stall        holds the pipeline
//   busy         operation iterating
//   done         one-cycle result-valid pulse
//   div_by_zero  qualifies done for a divide with a zero divisor
//   hi/lo        HI/LO registers
module muldiv_sequencer #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] rs_val,
   input  logic [DATA_WIDTH-1:0] rt_val,
   input  logic                  flush,
   input  logic                  hi_we,
   input  logic                  lo_we,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  stall,
   output logic                  busy,
   output logic                  done,
   output logic                  div_by_zero,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo
);

   localparam int unsigned W    = DATA_WIDTH;
   localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e          state_q;
   logic [CntW-1:0] cnt_q;
   logic [2*W-1:0]  acc_q;      // product, or remainder:quotient
   logic [W-1:0]    opnd_q;     // multiplicand magnitude or divisor magnitude
   logic            is_div_q;
   logic            neg_q;      // product / quotient must be negated
   logic            rs_neg_q;   // remainder must be negated
   logic [W-1:0]    hi_q, lo_q;
   logic            done_q, dbz_q;

   // Operand decode
   logic         op_signed, rs_neg, rt_neg, accept, mt_ok;
   logic [W-1:0] rs_mag, rt_mag;

   always_comb begin
      op_signed = ~op[0];
      rs_neg    = op_signed & rs_val[W-1];
      rt_neg    = op_signed & rt_val[W-1];
      rs_mag    = rs_neg ? (~rs_val + 1'b1) : rs_val;
      rt_mag    = rt_neg ? (~rt_val + 1'b1) : rt_val;
      accept    = (state_q == StIdle) & start & ~flush;
      // MT writes lose to an accepted start and are blocked while iterating
      mt_ok     = ((state_q == StIdle) & ~accept) | (state_q == StDone);
   end

   // One iteration of each algorithm
   logic [W:0]     mul_sum, div_top, div_diff;
   logic           div_ok;
   logic [2*W-1:0] mul_next, div_next, acc_d;
   logic [2*W-1:0] prod;
   logic [W-1:0]   quo, rem, res_hi, res_lo;

   always_comb begin
      // Shift-add: add multiplicand into the upper half when the LSB is set, then shift right
      mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
      mul_next = {mul_sum, acc_q[W-1:1]};

      // Restoring divide: shift left, subtract divisor from the W+1-bit partial remainder
      div_top  = acc_q[2*W-1:W-1];
      div_ok   = div_top >= {1'b0, opnd_q};
      div_diff = div_top - {1'b0, opnd_q};
      div_next = div_ok ? {div_diff[W-1:0], acc_q[W-2:0], 1'b1}
                        : {div_top[W-1:0], acc_q[W-2:0], 1'b0};

      acc_d = is_div_q ? div_next : mul_next;

      // Sign correction of the final iteration's value
      prod = neg_q ? (~acc_d + 1'b1) : acc_d;
      quo  = neg_q ? (~acc_d[W-1:0] + 1'b1) : acc_d[W-1:0];
      rem  = rs_neg_q ? (~acc_d[2*W-1:W] + 1'b1) : acc_d[2*W-1:W];

      res_hi = is_div_q ? rem : prod[2*W-1:W];
      res_lo = is_div_q ? quo : prod[W-1:0];
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rs_neg_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  opnd_q   <= op[1] ? rt_mag : rs_mag;
                  acc_q    <= {{W{1'b0}}, (op[1] ? rs_mag : rt_mag)};
                  cnt_q    <= '0;
                  is_div_q <= op[1];
                  neg_q    <= rs_neg ^ rt_neg;
                  rs_neg_q <= rs_neg;
                  if (op[1] && (rt_val == '0)) begin
                     // Zero divisor: skip iteration, leave HI/LO untouched
                     state_q <= StDone;
                     done_q  <= 1'b1;
                     dbz_q   <= 1'b1;
                  end else begin
                     state_q <= StBusy;
                  end
               end
            end
            StBusy: begin
               if (flush) begin
                  state_q <= StIdle;
               end else begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == CntW'(W - 1)) begin
                     hi_q    <= res_hi;
                     lo_q    <= res_lo;
                     state_q <= StDone;
                     done_q  <= 1'b1;
                  end
               end
            end
            StDone: begin
               // start is ignored: the same instruction is leaving EX
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
         // Later assignment overrides a result committed at the same edge
         if (mt_ok && hi_we) hi_q <= wdata;
         if (mt_ok && lo_we) lo_q <= wdata;
      end
   end

   always_comb begin
      stall       = ~Reset & ((state_q == StBusy) | accept);
      busy        = (state_q == StBusy);
      done        = done_q;
      div_by_zero = dbz_q;
      hi          = hi_q;
      lo          = lo_q;
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_val, rt_val;
   logic        flush, hi_we, lo_we;
   logic [31:0] wdata;
   logic        stall, busy, done, div_by_zero;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;
   int stall_n, done_n, dbz_n;
   bit got;

   muldiv_sequencer #(.DATA_WIDTH(32)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .start       (start),
      .op          (op),
      .rs_val      (rs_val),
      .rt_val      (rt_val),
      .flush       (flush),
      .hi_we       (hi_we),
      .lo_we       (lo_we),
      .wdata       (wdata),
      .stall       (stall),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one op, keep start high until done is seen, then drop it after the
   // DONE->IDLE edge. Counts stall/done/div_by_zero cycles over a fixed window.
   task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      bit dropped;
      dropped = 1'b0;
      stall_n = 0;
      done_n  = 0;
      dbz_n   = 0;
      @(posedge Clk); #1;
      start = 1'b1; op = o; rs_val = a; rt_val = b;
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         if (stall === 1'b1) stall_n++;
         if (done === 1'b1) done_n++;
         if (div_by_zero === 1'b1) dbz_n++;
         if (done === 1'b1 && !dropped) begin
            @(posedge Clk); #1;
            start   = 1'b0;
            dropped = 1'b1;
         end
      end
      start = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
      flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
      #12;
      check("rst_hi", hi, 32'h0);
      check("rst_lo", lo, 32'h0);
      check("rst_stall", {31'b0, stall}, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'h0);
      check("rst_done", {31'b0, done}, 32'h0);
      check("rst_dbz", {31'b0, div_by_zero}, 32'h0);
      @(posedge Clk); #1;
      Reset = 1'b0;

      // MULTU max*max, start held through DONE
      do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("multu_stall_cycles", stall_n, 33);
      check("multu_done_cycles", done_n, 1);
      check("multu_dbz_cycles", dbz_n, 0);
      check("multu_hi", hi, 32'hFFFF_FFFE);
      check("multu_lo", lo, 32'h0000_0001);

      do_op(2'b00, 32'hFFFF_FFFD, 32'd7);
      check("mult_neg_hi", hi, 32'hFFFF_FFFF);
      check("mult_neg_lo", lo, 32'hFFFF_FFEB);

      do_op(2'b00, 32'h8000_0000, 32'h8000_0000);
      check("mult_min_hi", hi, 32'h4000_0000);
      check("mult_min_lo", lo, 32'h0);

      do_op(2'b10, 32'hFFFF_FFF9, 32'd2);
      check("div_neg_lo", lo, 32'hFFFF_FFFD);
      check("div_neg_hi", hi, 32'hFFFF_FFFF);

      do_op(2'b11, 32'd7, 32'd2);
      check("divu_lo", lo, 32'd3);
      check("divu_hi", hi, 32'd1);

      do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      check("div_ovf_lo", lo, 32'h8000_0000);
      check("div_ovf_hi", hi, 32'h0);
      check("div_ovf_dbz_cycles", dbz_n, 0);

      // MTHI/MTLO preload in IDLE
      @(posedge Clk); #1; hi_we = 1'b1; wdata = 32'h11;
      @(posedge Clk); #1; hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
      @(posedge Clk); #1; lo_we = 1'b0;
      check("mt_hi", hi, 32'h11);
      check("mt_lo", lo, 32'h22);

      // Divide by zero
      do_op(2'b10, 32'd5, 32'd0);
      check("dbz_stall_cycles", stall_n, 1);
      check("dbz_done_cycles", done_n, 1);
      check("dbz_flag_cycles", dbz_n, 1);
      check("dbz_hi", hi, 32'h11);
      check("dbz_lo", lo, 32'h22);

      // Flush at BUSY counter=10
      @(posedge Clk); #1; start = 1'b1; op = 2'b01; rs_val = 32'd5; rt_val = 32'd6;
      @(posedge Clk); #1;
      repeat (10) @(posedge Clk);
      #1; flush = 1'b1;
      @(negedge Clk);
      check("flush_busy_before", {31'b0, busy}, 32'h1);
      @(posedge Clk); #1; flush = 1'b0; start = 1'b0;
      check("flush_busy_after", {31'b0, busy}, 32'h0);
      check("flush_stall_after", {31'b0, stall}, 32'h0);
      done_n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         if (done === 1'b1) done_n++;
      end
      check("flush_no_done", done_n, 0);
      check("flush_hi", hi, 32'h11);
      check("flush_lo", lo, 32'h22);

      // Reset mid-BUSY, start still high
      @(posedge Clk); #1; start = 1'b1; op = 2'b01; rs_val = 32'd5; rt_val = 32'd6;
      repeat (6) @(posedge Clk);
      @(negedge Clk);
      check("rstmid_busy_before", {31'b0, busy}, 32'h1);
      Reset = 1'b1;
      #1;
      check("rstmid_stall", {31'b0, stall}, 32'h0);
      check("rstmid_busy", {31'b0, busy}, 32'h0);
      check("rstmid_hi", hi, 32'h0);
      check("rstmid_lo", lo, 32'h0);
      start = 1'b0;
      @(posedge Clk); #1; Reset = 1'b0;

      // MTHI during BUSY is ignored
      @(posedge Clk); #1; start = 1'b1; op = 2'b01; rs_val = 32'd5; rt_val = 32'd6;
      repeat (3) @(posedge Clk);
      #1; hi_we = 1'b1; wdata = 32'hAB;
      repeat (10) @(posedge Clk);
      #1; hi_we = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         if (done === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      check("busy_mt_done_seen", {31'b0, got}, 32'h1);
      @(posedge Clk); #1; start = 1'b0;
      check("busy_mt_hi", hi, 32'h0);
      check("busy_mt_lo", lo, 32'h1E);

      // Same MTHI in IDLE takes effect
      @(posedge Clk); #1; hi_we = 1'b1; wdata = 32'hAB;
      @(posedge Clk); #1; hi_we = 1'b0;
      check("idle_mt_hi", hi, 32'hAB);
      check("idle_mt_lo", lo, 32'h1E);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
